// File: rtl/hazard_flush_controller_pkg.sv
// Shared types and constants for the hazard/flush controller and its helpers.
package hazard_flush_controller_pkg;

    typedef enum logic {
        HFC_RUN   = 1'b0,
        HFC_DRAIN = 1'b1
    } hfc_state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // A source register hazards against EX only when it is actually read and names EX's destination.
    function automatic logic src_matches(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
        return uses & (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_flush_controller_load_use_detector.sv
// Combinational load-use hazard detection between the load in EX and the instruction in ID.
module load_use_detector
    import hazard_flush_controller_pkg::*;
(
    input  logic [4:0] ID_rs1,
    input  logic [4:0] ID_rs2,
    input  logic       ID_uses_rs1,
    input  logic       ID_uses_rs2,
    input  logic       EX_memory_read,
    input  logic [4:0] EX_rd,
    output logic       load_use
);

    // x0 never carries a value, so a load targeting it cannot create a hazard.
    always_comb begin
        load_use = EX_memory_read & (EX_rd != REG_X0) &
                   (src_matches(ID_uses_rs1, ID_rs1, EX_rd) |
                    src_matches(ID_uses_rs2, ID_rs2, EX_rd));
    end

endmodule

// File: rtl/hazard_flush_controller.sv
// Stall/flush/redirect control for the RV32I front end and the ID/EX register.
// Optional performance counters are enabled with the HAZARD_PERF_COUNTERS_EN macro.
module hazard_flush_controller
    import hazard_flush_controller_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      ID_rs1,
    input  logic [4:0]      ID_rs2,
    input  logic            ID_uses_rs1,
    input  logic            ID_uses_rs2,
    input  logic            ID_serialize,
    input  logic            EX_memory_read,
    input  logic [4:0]      EX_rd,
    input  logic            EX_branch,
    input  logic            EX_jump,
    input  logic            EX_branch_taken,
    input  logic            EX_branch_estimation,
    input  logic [XLEN-1:0] EX_pc_plus_4,
    input  logic [XLEN-1:0] EX_branch_target,
`ifdef HAZARD_PERF_COUNTERS_EN
    output logic [31:0]     mispredict_count,
    output logic [31:0]     stall_cycle_count,
`endif
    output logic            pc_stall,
    output logic            IF_ID_stall,
    output logic            IF_ID_flush,
    output logic            ID_EX_flush,
    output logic            pc_redirect,
    output logic [XLEN-1:0] pc_redirect_target,
    output logic            busy
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    hfc_state_e       state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             load_use;
    logic             mispredict;

    load_use_detector u_load_use_detector (
        .ID_rs1         (ID_rs1),
        .ID_rs2         (ID_rs2),
        .ID_uses_rs1    (ID_uses_rs1),
        .ID_uses_rs2    (ID_uses_rs2),
        .EX_memory_read (EX_memory_read),
        .EX_rd          (EX_rd),
        .load_use       (load_use)
    );

    assign mispredict = EX_jump | (EX_branch & (EX_branch_taken != EX_branch_estimation));

    // State and drain counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= HFC_RUN;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Next-state logic; a mispredict squashes any serializing instruction in ID.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            HFC_RUN: begin
                if (!mispredict && !load_use && ID_serialize) begin
                    state_d     = HFC_DRAIN;
                    drain_cnt_d = CNT_W'(DRAIN_CYCLES);
                end else begin
                    state_d     = HFC_RUN;
                    drain_cnt_d = '0;
                end
            end
            HFC_DRAIN: begin
                if (mispredict || (drain_cnt_q == CNT_W'(1))) begin
                    state_d     = HFC_RUN;
                    drain_cnt_d = '0;
                end else begin
                    state_d     = HFC_DRAIN;
                    drain_cnt_d = drain_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d     = HFC_RUN;
                drain_cnt_d = '0;
            end
        endcase
    end

    // Mealy outputs; redirect always wins over stalls so stall and flush never coincide.
    always_comb begin
        pc_stall    = 1'b0;
        IF_ID_stall = 1'b0;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        pc_redirect = 1'b0;
        busy        = 1'b0;
        if (reset) begin
            pc_redirect = 1'b0;
        end else if (mispredict) begin
            pc_redirect = 1'b1;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else begin
            case (state_q)
                HFC_RUN: begin
                    if (load_use) begin
                        pc_stall    = 1'b1;
                        IF_ID_stall = 1'b1;
                        ID_EX_flush = 1'b1;
                    end else begin
                        ID_EX_flush = 1'b0;
                    end
                end
                HFC_DRAIN: begin
                    pc_stall    = 1'b1;
                    IF_ID_stall = 1'b1;
                    ID_EX_flush = 1'b1;
                    busy        = 1'b1;
                end
                default: begin
                    busy = 1'b0;
                end
            endcase
        end
    end

    // Redirect target selection, zero whenever no redirect is requested.
    always_comb begin
        if (!pc_redirect) begin
            pc_redirect_target = '0;
        end else if (EX_jump || EX_branch_taken) begin
            pc_redirect_target = EX_branch_target;
        end else begin
            pc_redirect_target = EX_pc_plus_4;
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] mispredict_count_q, mispredict_count_d;
    logic [31:0] stall_cycle_count_q, stall_cycle_count_d;

    // Counters wrap naturally modulo 2^32.
    always_comb begin
        mispredict_count_d  = mispredict_count_q + {31'd0, pc_redirect};
        stall_cycle_count_d = stall_cycle_count_q + {31'd0, pc_stall};
    end

    // Performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_count_q  <= 32'd0;
            stall_cycle_count_q <= 32'd0;
        end else begin
            mispredict_count_q  <= mispredict_count_d;
            stall_cycle_count_q <= stall_cycle_count_d;
        end
    end

    assign mispredict_count  = mispredict_count_q;
    assign stall_cycle_count = stall_cycle_count_q;
`endif

endmodule

// File: tb/tb_hazard_flush_controller.sv
// Directed self-checking bench for hazard_flush_controller (covers HAZARD_PERF_COUNTERS_EN when defined).
module tb_hazard_flush_controller;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      ID_rs1, ID_rs2, EX_rd;
    logic            ID_uses_rs1, ID_uses_rs2, ID_serialize;
    logic            EX_memory_read, EX_branch, EX_jump, EX_branch_taken, EX_branch_estimation;
    logic [XLEN-1:0] EX_pc_plus_4, EX_branch_target;
    logic            pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, pc_redirect, busy;
    logic [XLEN-1:0] pc_redirect_target;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0]     mispredict_count, stall_cycle_count;
`endif

    int checks = 0;
    int errors = 0;

    hazard_flush_controller #(.XLEN(XLEN), .DRAIN_CYCLES(3)) dut (
        .clk                  (clk),
        .reset                (reset),
        .ID_rs1               (ID_rs1),
        .ID_rs2               (ID_rs2),
        .ID_uses_rs1          (ID_uses_rs1),
        .ID_uses_rs2          (ID_uses_rs2),
        .ID_serialize         (ID_serialize),
        .EX_memory_read       (EX_memory_read),
        .EX_rd                (EX_rd),
        .EX_branch            (EX_branch),
        .EX_jump              (EX_jump),
        .EX_branch_taken      (EX_branch_taken),
        .EX_branch_estimation (EX_branch_estimation),
        .EX_pc_plus_4         (EX_pc_plus_4),
        .EX_branch_target     (EX_branch_target),
`ifdef HAZARD_PERF_COUNTERS_EN
        .mispredict_count     (mispredict_count),
        .stall_cycle_count    (stall_cycle_count),
`endif
        .pc_stall             (pc_stall),
        .IF_ID_stall          (IF_ID_stall),
        .IF_ID_flush          (IF_ID_flush),
        .ID_EX_flush          (ID_EX_flush),
        .pc_redirect          (pc_redirect),
        .pc_redirect_target   (pc_redirect_target),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    // Output bits: {pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, pc_redirect, busy}
    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_LU    = 6'b110100;
    localparam logic [5:0] O_REDIR = 6'b001110;
    localparam logic [5:0] O_DRAIN = 6'b110101;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0;
        ID_serialize = 1'b0; EX_memory_read = 1'b0; EX_rd = 5'd0;
        EX_branch = 1'b0; EX_jump = 1'b0; EX_branch_taken = 1'b0; EX_branch_estimation = 1'b0;
        EX_pc_plus_4 = 32'h0000_0104; EX_branch_target = 32'h0000_0300;
    endtask

    // Inputs are already applied; sample mid-cycle, then advance past the next edge.
    task automatic cyc(input string tag, input logic [5:0] exp_o, input logic [31:0] exp_t);
        #1;
        check_eq({tag, ".outs"}, {26'd0, pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, pc_redirect, busy},
                 {26'd0, exp_o});
        check_eq({tag, ".target"}, pc_redirect_target, exp_t);
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        EX_memory_read = 1'b1; EX_rd = 5'd5; ID_rs2 = 5'd5; ID_uses_rs2 = 1'b1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        EX_jump = 1'b1; EX_branch_target = 32'h0000_0200;
        @(posedge clk); #1;
        cyc("reset_forces_zero", O_IDLE, 32'd0);
        reset = 1'b0;
        clear_inputs();
        cyc("idle", O_IDLE, 32'd0);

        // Load-use: one bubble, then the flushed ID/EX drops the load.
        set_load_use();
        cyc("load_use_rs2", O_LU, 32'd0);
        EX_memory_read = 1'b0;
        cyc("load_use_released", O_IDLE, 32'd0);
        clear_inputs();
        EX_memory_read = 1'b1; EX_rd = 5'd7; ID_rs1 = 5'd7; ID_uses_rs1 = 1'b1;
        cyc("load_use_rs1", O_LU, 32'd0);
        ID_uses_rs1 = 1'b0;
        cyc("rs1_not_used", O_IDLE, 32'd0);
        clear_inputs();
        EX_memory_read = 1'b1; EX_rd = 5'd0; ID_rs1 = 5'd0; ID_uses_rs1 = 1'b1;
        cyc("load_x0_no_stall", O_IDLE, 32'd0);

        // Branch outcomes.
        clear_inputs();
        EX_branch = 1'b1; EX_branch_estimation = 1'b1; EX_branch_taken = 1'b0;
        cyc("mispredict_not_taken", O_REDIR, 32'h0000_0104);
        EX_branch_estimation = 1'b0; EX_branch_taken = 1'b1;
        cyc("mispredict_taken", O_REDIR, 32'h0000_0300);
        EX_branch_estimation = 1'b1;
        cyc("predicted_correct", O_IDLE, 32'd0);

        // Jump beats simultaneous load-use and serialize.
        clear_inputs();
        EX_jump = 1'b1; EX_branch_target = 32'h0000_0200; ID_serialize = 1'b1;
        set_load_use();
        cyc("jump_priority", O_REDIR, 32'h0000_0200);
        clear_inputs();
        cyc("jump_stays_run", O_IDLE, 32'd0);

        // Serialize: entry cycle quiet, three drain cycles (load-use ignored), then RUN.
        ID_serialize = 1'b1;
        cyc("serialize_entry", O_IDLE, 32'd0);
        clear_inputs();
        set_load_use();
        cyc("drain_1", O_DRAIN, 32'd0);
        clear_inputs();
        ID_serialize = 1'b1;
        cyc("drain_2", O_DRAIN, 32'd0);
        clear_inputs();
        cyc("drain_3", O_DRAIN, 32'd0);
        cyc("drain_done", O_IDLE, 32'd0);

        // Reset during the second drain cycle aborts the drain.
        ID_serialize = 1'b1;
        cyc("serialize_entry_b", O_IDLE, 32'd0);
        ID_serialize = 1'b0;
        cyc("drain_b1", O_DRAIN, 32'd0);
        reset = 1'b1;
        cyc("reset_in_drain", O_IDLE, 32'd0);
        reset = 1'b0;
        cyc("after_reset_run", O_IDLE, 32'd0);
        ID_serialize = 1'b1;
        cyc("serialize_entry_c", O_IDLE, 32'd0);
        ID_serialize = 1'b0;
        cyc("drain_c1", O_DRAIN, 32'd0);
        cyc("drain_c2", O_DRAIN, 32'd0);
        cyc("drain_c3", O_DRAIN, 32'd0);
        cyc("drain_c_done", O_IDLE, 32'd0);

        // Mispredict inside DRAIN redirects and returns to RUN.
        ID_serialize = 1'b1;
        cyc("serialize_entry_d", O_IDLE, 32'd0);
        ID_serialize = 1'b0;
        cyc("drain_d1", O_DRAIN, 32'd0);
        EX_jump = 1'b1;
        cyc("mispredict_in_drain", O_REDIR, 32'h0000_0300);
        clear_inputs();
        cyc("after_drain_redirect", O_IDLE, 32'd0);

`ifdef HAZARD_PERF_COUNTERS_EN
        reset = 1'b1;
        cyc("perf_reset", O_IDLE, 32'd0);
        reset = 1'b0;
        check_eq("perf_clear_mis", mispredict_count, 32'd0);
        EX_jump = 1'b1;
        cyc("perf_mis1", O_REDIR, 32'h0000_0300);
        clear_inputs();
        EX_branch = 1'b1; EX_branch_estimation = 1'b1;
        cyc("perf_mis2", O_REDIR, 32'h0000_0104);
        clear_inputs();
        set_load_use();
        cyc("perf_lu", O_LU, 32'd0);
        clear_inputs();
        check_eq("mispredict_count", mispredict_count, 32'd2);
        check_eq("stall_cycle_count", stall_cycle_count, 32'd1);
        force dut.mispredict_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.mispredict_count_q;
        EX_jump = 1'b1;
        cyc("perf_wrap_redirect", O_REDIR, 32'h0000_0300);
        clear_inputs();
        check_eq("mispredict_count_wrap", mispredict_count, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_flush_controller.md
# hazard_flush_controller

Control-side counterpart of the ID/EX pipeline register. It drives that register's `flush` input and the matching stall and redirect signals for PC and IF/ID, based on three inputs: load-use hazards, branch/jump resolution in EX, and serializing instructions (CSR write, FENCE, ECALL) decoded in ID. It is a small Mealy FSM with a drain counter and sits beside the decoder in the RV32I core.

## Interface
- `XLEN`, 32, datapath/PC width
- `DRAIN_CYCLES`, 3, bubble cycles inserted after a serializing instruction enters EX (1..15)
- `clk`  in  1  core clock
- `reset`  in  1  synchronous, active-high
- `ID_rs1`, `ID_rs2`  in  5 each  source registers of the instruction in ID
- `ID_uses_rs1`, `ID_uses_rs2`  in  1 each  source actually read
- `ID_serialize`  in  1  instruction in ID is serializing
- `EX_memory_read`  in  1  instruction in EX is a load
- `EX_rd`  in  5  destination of the instruction in EX
- `EX_branch`, `EX_jump`  in  1 each  EX holds a branch / JAL / JALR
- `EX_branch_taken`  in  1  actual branch outcome
- `EX_branch_estimation`  in  1  prediction carried with the instruction
- `EX_pc_plus_4`, `EX_branch_target`  in  XLEN each  fall-through and target addresses
- `pc_stall`  out  1  hold the PC
- `IF_ID_stall`  out  1  hold IF/ID
- `IF_ID_flush`  out  1  bubble IF/ID
- `ID_EX_flush`  out  1  bubble ID/EX (drives its `flush`)
- `pc_redirect`  out  1  load `pc_redirect_target` into the PC
- `pc_redirect_target`  out  XLEN  redirect address
- `busy`  out  1  FSM is in DRAIN

## Operation
- `mispredict = EX_jump | (EX_branch & (EX_branch_taken != EX_branch_estimation))`.
- Redirect target:
  - `EX_branch_target` if `EX_jump` or `EX_branch_taken`.
  - Otherwise `EX_pc_plus_4`.
  - 0 when `pc_redirect` = 0.
- `load_use = EX_memory_read & EX_rd != 0 & ((ID_uses_rs1 & ID_rs1 == EX_rd) | (ID_uses_rs2 & ID_rs2 == EX_rd))`.
- States: RUN, DRAIN. Counter `drain_cnt` is `$clog2(DRAIN_CYCLES+1)` bits wide.
- RUN priority, highest first:
  1. `mispredict`: `pc_redirect` = 1, `IF_ID_flush` = 1, `ID_EX_flush` = 1. Stay in RUN. Any `ID_serialize` is squashed.
  2. `load_use`: `pc_stall` = 1, `IF_ID_stall` = 1, `ID_EX_flush` = 1.
  3. `ID_serialize`: no outputs asserted; the instruction advances into EX. Next state DRAIN, `drain_cnt` = `DRAIN_CYCLES`.
  4. Otherwise: all outputs 0.
- DRAIN:
  - Outputs: `pc_stall` = 1, `IF_ID_stall` = 1, `ID_EX_flush` = 1, `busy` = 1.
  - `drain_cnt` decrements each cycle. When `drain_cnt` = 1, the next state is RUN.
  - `load_use` and `ID_serialize` are ignored in DRAIN.
  - `mispredict` in DRAIN applies the RUN item-1 outputs (redirect overrides the stalls: `pc_stall` = `IF_ID_stall` = 0), next state RUN, `drain_cnt` cleared.
- Stall and flush of the same register are never asserted together.

## Timing
- All outputs are combinational from state and inputs within the same cycle. State and counter update on the `posedge clk`.
- Reset:
  - While `reset` is high, every output is forced to 0. On the next edge, state becomes RUN, `drain_cnt` 0, counters 0.
  - Reset in mid-DRAIN aborts the drain immediately.
- Latencies:
  - Load-use produces exactly one bubble, because the flushed ID/EX clears `EX_memory_read` on the next cycle.
  - A mispredict costs 2 cycles.
  - A serializing instruction costs `DRAIN_CYCLES` bubbles. `busy` is high for exactly `DRAIN_CYCLES` cycles, starting the cycle after entry.

## Configuration
- `HAZARD_PERF_COUNTERS_EN` defined: adds two outputs, `mispredict_count` [31:0] and `stall_cycle_count` [31:0].
  - `mispredict_count` increments on every cycle with `pc_redirect` = 1.
  - `stall_cycle_count` increments on every cycle with `pc_stall` = 1.
  - Both wrap modulo 2^32 and clear on reset.
- Not defined: those ports and registers do not exist. All other behaviour is identical.

## Structure
- Shared package holds:
  - state enum `HFC_RUN` = 1'b0, `HFC_DRAIN` = 1'b1;
  - `REG_X0` = 5'd0.
- One sub-module, `load_use_detector`, which is purely combinational. Everything else lives in the top.

## Test plan
- Load-use: EX `lw x5` (`EX_memory_read` = 1, `EX_rd` = 5), ID `add` with `ID_rs2` = 5 used -> one cycle of `pc_stall` = `IF_ID_stall` = `ID_EX_flush` = 1. With `EX_rd` = 0 -> no stall.
- Mispredict, not-taken side: `EX_branch` = 1, estimation 1, taken 0, `EX_pc_plus_4` = 0x104 -> `pc_redirect` = 1, target 0x104, `IF_ID_flush` = `ID_EX_flush` = 1.
- Jump: `EX_jump` = 1, `EX_branch_target` = 0x200, simultaneous `load_use` and `ID_serialize` -> redirect to 0x200, no stall, stays RUN.
- Serialize: `ID_serialize` pulse with `DRAIN_CYCLES` = 3 -> entry cycle all outputs 0, then exactly 3 cycles with `busy`/stall/flush high, then RUN.
- Reset on the 2nd DRAIN cycle -> outputs 0 while reset is high, RUN afterwards, next `ID_serialize` drains the full 3 cycles.
- With `HAZARD_PERF_COUNTERS_EN`: 2 mispredicts plus 1 load-use -> `mispredict_count` = 2, `stall_cycle_count` = 1. A counter preloaded to 0xFFFFFFFF by forcing wraps to 0.
